multicycle_cpu: RTL and testbench

- Parametrised multicycle RV32I integer core; successor to the single-cycle fetch/regfile/ALU datapath.
- Fetches through a valid handshake that tolerates wait states and decodes R-type and I-type ALU instructions.
- Traps on anything it does not support.
- Sits between instruction memory and the debug/retire monitors; data memory ports stay outside this block.

---
 rtl/multicycle_pkg.sv | 32 +++
 rtl/multicycle_cpu_if.sv | 13 +
 rtl/mc_regfile.sv | 41 ++++
 rtl/multicycle_cpu.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_pkg.sv
// Shared constants and types for the multicycle integer core: FSM state codes,
// RV32I opcode/funct fields and the ALU operation set.
package multicycle_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

endpackage

// File: rtl/multicycle_cpu_if.sv
// Instruction-fetch bus: the core drives address/request, memory returns
// the word with a single-cycle valid strobe.
interface multicycle_cpu_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] iaddr;
    logic            ireq;
    logic [31:0]     idata;
    logic            ivalid;

    modport master (output iaddr, ireq, input idata, ivalid);
    modport slave  (input iaddr, ireq, output idata, ivalid);
endinterface

// File: rtl/mc_regfile.sv
// Architectural register file: two asynchronous read ports, one write port,
// x0 hardwired to zero, and a debug tap on the highest register.
module mc_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] dbg_last
);
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wa] = wd;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1      = regs_q[ra1];
    assign rd2      = regs_q[ra2];
    assign dbg_last = regs_q[NREGS-1];
endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle RV32I/RV64I core executing R/I-type ALU instructions one at a time;
// anything unsupported parks the core in TRAP until reset.
//
// state  | meaning
// IDLE   | one cycle after reset release before the first fetch
// FETCH  | ireq high, waiting for ivalid
// DECODE | legality check, operands latched
// EXEC   | ALU result registered
// WB     | rd written, PC advanced, retire pulse
// TRAP   | terminal illegal-instruction state
module multicycle_cpu
    import multicycle_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_cpu_if.master fbus,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [XLEN-1:0]  dbg_xlast
);
    localparam int AW  = $clog2(NREGS);
    localparam int SHW = $clog2(XLEN);

    logic [2:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    alu_op_e          op_q, op_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             ireq_q, ireq_d, retire_q, retire_d, trap_q, trap_d;

    logic [6:0]      opcode, f7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic            is_r, is_i, idx_ok, f7_ok, illegal, rf_we;
    logic            sh_base, sh_alt, sh_lo_ok;
    logic [XLEN-1:0] imm, rd1, rd2, alu_y;
    logic [SHW-1:0]  shamt;
    alu_op_e         dec_op;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];
    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign imm    = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign idx_ok = (int'(rd) < NREGS) && (int'(rs1) < NREGS) && (!is_r || int'(rs2) < NREGS);

    // Shift immediates: bit 25 is shamt[5] on RV64 but must be zero on RV32.
    assign sh_base  = (ir_q[31:26] == 6'b000000);
    assign sh_alt   = (ir_q[31:26] == 6'b010000);
    assign sh_lo_ok = (XLEN == 64) || !ir_q[25];

    always_comb begin
        dec_op = ALU_ADD;
        f7_ok  = 1'b0;
        case (f3)
            F3_ADD: begin
                dec_op = (is_r && ir_q[30]) ? ALU_SUB : ALU_ADD;
                f7_ok  = is_i || f7 == F7_BASE || f7 == F7_ALT;
            end
            F3_SLL: begin
                dec_op = ALU_SLL;
                f7_ok  = is_r ? (f7 == F7_BASE) : (sh_base && sh_lo_ok);
            end
            F3_SR: begin
                dec_op = ir_q[30] ? ALU_SRA : ALU_SRL;
                f7_ok  = is_r ? (f7 == F7_BASE || f7 == F7_ALT) : ((sh_base || sh_alt) && sh_lo_ok);
            end
            F3_SLT:  begin dec_op = ALU_SLT;  f7_ok = is_i || f7 == F7_BASE; end
            F3_SLTU: begin dec_op = ALU_SLTU; f7_ok = is_i || f7 == F7_BASE; end
            F3_XOR:  begin dec_op = ALU_XOR;  f7_ok = is_i || f7 == F7_BASE; end
            F3_OR:   begin dec_op = ALU_OR;   f7_ok = is_i || f7 == F7_BASE; end
            F3_AND:  begin dec_op = ALU_AND;  f7_ok = is_i || f7 == F7_BASE; end
            default: begin dec_op = ALU_ADD;  f7_ok = 1'b0; end
        endcase
    end

    assign illegal = !(is_r || is_i) || !f7_ok || !idx_ok;
    assign shamt   = b_q[SHW-1:0];

    always_comb begin
        alu_y = '0;
        case (op_q)
            ALU_ADD:  alu_y = a_q + b_q;
            ALU_SUB:  alu_y = a_q - b_q;
            ALU_SLL:  alu_y = a_q << shamt;
            ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, a_q < b_q};
            ALU_XOR:  alu_y = a_q ^ b_q;
            ALU_SRL:  alu_y = a_q >> shamt;
            ALU_SRA:  alu_y = XLEN'($signed(a_q) >>> shamt);
            ALU_OR:   alu_y = a_q | b_q;
            ALU_AND:  alu_y = a_q & b_q;
            default:  alu_y = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        instret_d = instret_q;
        rf_we     = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (ireq_q && fbus.ivalid) begin
                    ir_d    = fbus.idata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (illegal) begin
                    state_d = ST_TRAP;
                end else begin
                    a_d     = rd1;
                    b_d     = is_r ? rd2 : imm;
                    op_d    = dec_op;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = alu_y;
                state_d = ST_WB;
            end
            ST_WB: begin
                rf_we     = (rd != 5'd0);
                pc_d      = pc_q + XLEN'(4);
                instret_d = instret_q + CNT_W'(1);
                state_d   = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are flops keyed off the upcoming state so they are glitch-free.
    assign ireq_d   = (state_d == ST_FETCH);
    assign retire_d = (state_d == ST_WB);
    assign trap_d   = (state_d == ST_TRAP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= ALU_ADD;
            res_q     <= '0;
            instret_q <= '0;
            ireq_q    <= 1'b0;
            retire_q  <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_q     <= res_d;
            instret_q <= instret_d;
            ireq_q    <= ireq_d;
            retire_q  <= retire_d;
            trap_q    <= trap_d;
        end
    end

    mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .ra1      (ir_q[15 +: AW]),
        .ra2      (ir_q[20 +: AW]),
        .rd1      (rd1),
        .rd2      (rd2),
        .we       (rf_we),
        .wa       (ir_q[7 +: AW]),
        .wd       (res_q),
        .dbg_last (dbg_xlast)
    );

    assign fbus.iaddr = pc_q;
    assign fbus.ireq  = ireq_q;
    assign retire     = retire_q;
    assign instret    = instret_q;
    assign trap       = trap_q;
endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: directed vector table, randomized ALU programs
// checked against an ISA-level model, reset/trap corner sequences.
module tb_multicycle_cpu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0_n = 1'b0, rst1_n = 1'b0;
    logic        sel = 1'b0;
    logic        ivalid_drv = 1'b0;
    logic [31:0] idata_drv = '0;

    multicycle_cpu_if #(.XLEN(32)) bus0 ();
    multicycle_cpu_if #(.XLEN(32)) bus1 ();
    logic        retire0, retire1, trap0, trap1;
    logic [31:0] instret0, instret1, xlast0, xlast1;

    assign bus0.ivalid = ivalid_drv & ~sel;
    assign bus1.ivalid = ivalid_drv & sel;
    assign bus0.idata  = idata_drv;
    assign bus1.idata  = idata_drv;

    multicycle_cpu #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk(clk), .reset(rst0_n), .fbus(bus0), .retire(retire0),
        .instret(instret0), .trap(trap0), .dbg_xlast(xlast0));

    multicycle_cpu #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0), .CNT_W(32)) dut_e (
        .clk(clk), .reset(rst1_n), .fbus(bus1), .retire(retire1),
        .instret(instret1), .trap(trap1), .dbg_xlast(xlast1));

    wire        obs_ireq    = sel ? bus1.ireq  : bus0.ireq;
    wire [31:0] obs_iaddr   = sel ? bus1.iaddr : bus0.iaddr;
    wire        obs_retire  = sel ? retire1    : retire0;
    wire        obs_trap    = sel ? trap1      : trap0;
    wire [31:0] obs_instret = sel ? instret1   : instret0;
    wire [31:0] obs_xlast   = sel ? xlast1     : xlast0;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- ISA-level reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_pc, m_cnt;
    int          m_nregs = 32;

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc  = '0;
        m_cnt = '0;
    endfunction

    function automatic logic model_step(input logic [31:0] w);
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        int          rd, rs1, rs2, sh;
        logic        r;
        logic [31:0] a, b, res;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        rd = int'(w[11:7]); rs1 = int'(w[19:15]); rs2 = int'(w[24:20]);
        if (op != 7'h33 && op != 7'h13) return 1'b0;
        r = (op == 7'h33);
        if (rd >= m_nregs || rs1 >= m_nregs || (r && rs2 >= m_nregs)) return 1'b0;
        if (r && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) return 1'b0;
        if (!r && f3 == 3'd1 && f7 != 7'h00) return 1'b0;
        if (!r && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return 1'b0;
        a  = m_regs[rs1];
        b  = r ? m_regs[rs2] : {{20{w[31]}}, w[31:20]};
        sh = int'(b % 32);
        case (f3)
            3'd0: res = (r && f7 == 7'h20) ? a - b : a + b;
            3'd1: res = a << sh;
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: res = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: res = a | b;
            default: res = a & b;
        endcase
        if (rd != 0) m_regs[rd] = res;
        m_pc  = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
        return 1'b1;
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [11:0] imm;
        f3 = 3'($urandom_range(0, 7));
        rd = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) begin
            return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                         5'($urandom), 5'($urandom), f3, rd);
        end
        imm = 12'($urandom);
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return enc_i(imm, 5'($urandom), f3, rd);
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        ivalid_drv = 1'b0;
        @(negedge clk);
        if (sel) rst1_n = 1'b0; else rst0_n = 1'b0;
        @(negedge clk);
        ivalid_drv = 1'b1;
        @(negedge clk);
        ivalid_drv = 1'b0;
        chk("rst_ireq", obs_ireq, 0);
        chk("rst_retire", obs_retire, 0);
        chk("rst_trap", obs_trap, 0);
        chk("rst_instret", obs_instret, 0);
        chk("rst_xlast", obs_xlast, 0);
        chk("rst_iaddr", obs_iaddr, 0);
        if (sel) rst1_n = 1'b1; else rst0_n = 1'b1;
        m_reset();
        #1 chk("ireq_at_release", obs_ireq, 0);
        @(negedge clk);
        chk("ireq_after_release", obs_ireq, 1);
        chk("iaddr_after_release", obs_iaddr, 0);
    endtask

    task automatic run_instr(input logic [31:0] w, input int waits, input logic junk);
        logic [31:0] a0;
        logic        legal;
        int          n;
        n = 0;
        while (obs_ireq !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_ireq", obs_ireq, 1);
        chk("fetch_iaddr", obs_iaddr, m_pc);
        a0 = obs_iaddr;
        for (int i = 0; i < waits; i++) begin
            ivalid_drv = 1'b0;
            idata_drv  = $urandom;
            @(negedge clk);
            chk("wait_ireq", obs_ireq, 1);
            chk("wait_iaddr", obs_iaddr, a0);
        end
        idata_drv  = w;
        ivalid_drv = 1'b1;
        @(negedge clk);
        ivalid_drv = junk;
        idata_drv  = $urandom;
        chk("decode_ireq", obs_ireq, 0);
        chk("decode_retire", obs_retire, 0);
        legal = model_step(w);
        @(negedge clk);
        if (!legal) begin
            chk("trap_set", obs_trap, 1);
            chk("trap_ireq", obs_ireq, 0);
            chk("trap_pc", obs_iaddr, a0);
            chk("trap_instret", obs_instret, m_cnt);
            ivalid_drv = 1'b1;
            repeat (3) @(negedge clk);
            ivalid_drv = 1'b0;
            chk("trap_sticky", obs_trap, 1);
            chk("trap_ireq_hold", obs_ireq, 0);
            chk("trap_pc_hold", obs_iaddr, a0);
            chk("trap_no_retire", obs_retire, 0);
            chk("trap_instret_hold", obs_instret, m_cnt);
        end else begin
            chk("exec_retire", obs_retire, 0);
            chk("exec_trap", obs_trap, 0);
            @(negedge clk);
            ivalid_drv = 1'b0;
            chk("wb_retire", obs_retire, 1);
            @(negedge clk);
            chk("post_retire", obs_retire, 0);
            chk("pc", obs_iaddr, m_pc);
            chk("instret", obs_instret, m_cnt);
            chk("xlast", obs_xlast, m_regs[m_nregs-1]);
        end
    endtask

    typedef struct {
        logic [31:0] w;
        int          waits;
        logic [31:0] x31;
    } vec_t;
    vec_t        vt [25];
    logic [31:0] bad [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{32'h00500093, 0, 32'h0};                    // ADDI x1,x0,5
        vt[1]  = '{enc_i(12'h0, 1, 0, 31), 0, 32'h5};
        vt[2]  = '{32'hFF800113, 1, 32'h5};                    // ADDI x2,x0,-8
        vt[3]  = '{32'h40115193, 0, 32'h5};                    // SRAI x3,x2,1
        vt[4]  = '{enc_i(12'h0, 3, 0, 31), 2, 32'hFFFFFFFC};
        vt[5]  = '{enc_i(12'h0, 2, 0, 31), 0, 32'hFFFFFFF8};
        vt[6]  = '{32'h40208233, 0, 32'hFFFFFFF8};             // SUB x4,x1,x2
        vt[7]  = '{enc_i(12'h0, 4, 0, 31), 3, 32'h0000000D};
        vt[8]  = '{32'h00700013, 0, 32'h0000000D};             // ADDI x0,x0,7
        vt[9]  = '{enc_i(12'h0, 0, 0, 31), 0, 32'h0};
        vt[10] = '{enc_r(7'h00, 1, 2, 2, 31), 0, 32'h1};       // SLT
        vt[11] = '{enc_r(7'h00, 1, 2, 3, 31), 0, 32'h0};       // SLTU
        vt[12] = '{enc_r(7'h00, 1, 1, 1, 31), 0, 32'h000000A0};
        vt[13] = '{enc_r(7'h00, 1, 2, 5, 31), 0, 32'h07FFFFFF};
        vt[14] = '{enc_r(7'h20, 1, 2, 5, 31), 0, 32'hFFFFFFFF};
        vt[15] = '{enc_i(12'hFFF, 1, 4, 31), 0, 32'hFFFFFFFA}; // XORI
        vt[16] = '{enc_i(12'hFFF, 1, 3, 31), 0, 32'h1};        // SLTIU
        vt[17] = '{enc_i(12'h00F, 2, 7, 31), 0, 32'h8};        // ANDI
        vt[18] = '{enc_i(12'h7F0, 1, 6, 31), 0, 32'h000007F5}; // ORI
        vt[19] = '{enc_i(12'h01F, 1, 1, 31), 0, 32'h80000000}; // SLLI 31
        vt[20] = '{enc_r(7'h00, 31, 31, 0, 31), 0, 32'h0};     // ADD wraps
        vt[21] = '{enc_i(12'h7FF, 1, 2, 31), 0, 32'h1};        // SLTI
        vt[22] = '{enc_r(7'h00, 2, 1, 4, 31), 0, 32'hFFFFFFFD};
        vt[23] = '{enc_r(7'h00, 2, 1, 6, 31), 0, 32'hFFFFFFFD};
        vt[24] = '{enc_r(7'h00, 2, 1, 7, 31), 0, 32'h0};

        bad[0] = 32'h0000006F;                 // JAL
        bad[1] = 32'h40209233;                 // SLL with alt funct7
        bad[2] = 32'h02009093;                 // SLLI with imm[25]=1 on RV32
        bad[3] = 32'h02208233;                 // MUL
        bad[4] = 32'h00002083;                 // LW
        bad[5] = enc_r(7'h20, 2, 1, 4, 4);     // XOR with alt funct7

        sel = 1'b0;
        m_nregs = 32;
        do_reset();

        for (int i = 0; i < 25; i++) begin
            run_instr(vt[i].w, vt[i].waits, 1'(i % 2));
            chk("tbl_x31", obs_xlast, vt[i].x31);
        end
        chk("tbl_instret", obs_instret, 32'd25);
        chk("tbl_pc", obs_iaddr, 32'd100);

        for (int i = 0; i < 150; i++) begin
            run_instr(rand_legal(), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        for (int i = 1; i < 31; i++) begin
            run_instr(enc_i(12'h0, 5'(i), 0, 31), 0, 1'b0);
        end

        // Reset asserted asynchronously while ADDI x31,x0,9 sits in EXEC.
        chk("mid_ireq", obs_ireq, 1);
        idata_drv  = enc_i(12'd9, 0, 0, 31);
        ivalid_drv = 1'b1;
        @(negedge clk);
        ivalid_drv = 1'b0;
        @(negedge clk);
        #2 rst0_n = 1'b0;
        #1;
        chk("mid_rst_ireq", obs_ireq, 0);
        chk("mid_rst_retire", obs_retire, 0);
        chk("mid_rst_instret", obs_instret, 0);
        chk("mid_rst_trap", obs_trap, 0);
        chk("mid_rst_xlast", obs_xlast, 0);
        chk("mid_rst_iaddr", obs_iaddr, 0);
        @(negedge clk);
        rst0_n = 1'b1;
        m_reset();
        @(negedge clk);
        chk("mid_restart_ireq", obs_ireq, 1);
        chk("mid_restart_iaddr", obs_iaddr, 0);
        run_instr(enc_i(12'h0, 31, 0, 31), 0, 1'b0);

        // Each illegal word faults at PC=8 after two good instructions.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_instr(enc_i(12'd1, 0, 0, 1), 0, 1'b0);
            run_instr(enc_i(12'd2, 0, 0, 31), 1, 1'b1);
            run_instr(bad[i], 0, 1'b1);
            chk("bad_pc8", obs_iaddr, 32'd8);
            chk("bad_instret2", obs_instret, 32'd2);
        end

        sel = 1'b1;
        m_nregs = 16;
        do_reset();
        run_instr(32'h00300793, 0, 1'b0);       // ADDI x15,x0,3
        chk("e_x15", obs_xlast, 32'd3);
        run_instr(32'h00100A13, 0, 1'b0);       // ADDI x20,x0,1 -> trap
        chk("e_trap_x20", obs_trap, 1);
        chk("e_trap_pc", obs_iaddr, 32'd4);
        do_reset();
        run_instr(enc_r(7'h00, 0, 17, 0, 1), 0, 1'b0);
        chk("e_trap_rs1", obs_trap, 1);
        do_reset();
        run_instr(enc_i(12'hFFF, 0, 0, 15), 2, 1'b1);
        chk("e_recover", obs_xlast, 32'hFFFFFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
